// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings: transfer types, response codes and the
// default-slave state type used by the response multiplexer.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

endpackage

// File: rtl/ahb_def_slv.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response.
module ahb_def_slv
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hreset,
    input  logic start,
    input  logic hready,
    output logic ds_hready,
    output logic ds_hresp,
    output logic ds_active
);

    ds_state_e state_q, state_d;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        ds_active = 1'b0;
        unique case (state_q)
            DS_IDLE: begin
                if (start && hready) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
                ds_active = 1'b1;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp  = HRESP_ERROR;
                ds_active = 1'b1;
                // ERR2 drives hready high, so a new unmapped transfer can chain here
                state_d   = (start && hready) ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave response multiplexer: registers the address-phase select
// and routes the selected slave's data-phase response back to the master.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int unsigned slv_c = 4
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [slv_c-1:0]       hsel,
    input  logic [1:0]             htrans,
    input  logic [slv_c-1:0][31:0] hrdata_s,
    input  logic [slv_c-1:0]       hresp_s,
    input  logic [slv_c-1:0]       hreadyout_s,
    output logic [31:0]            hrdata,
    output logic                   hresp,
    output logic                   hready
);

    logic [slv_c-1:0] sel_dp_q, sel_dp_d;
    logic [slv_c-1:0] sel_pri;
    logic             ds_start;
    logic             ds_hready, ds_hresp, ds_active;

    always_comb begin
        sel_pri = '0;
        for (int unsigned i = 0; i < slv_c; i++) begin
            if (hsel[i] && (sel_pri == '0)) sel_pri[i] = 1'b1;
        end
    end

    assign ds_start = (hsel == '0) &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign sel_dp_d = hready ? sel_pri : sel_dp_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sel_dp_q <= '0;
        end else begin
            sel_dp_q <= sel_dp_d;
        end
    end

    ahb_def_slv u_def_slv (
        .hclk      (hclk),
        .hreset    (hreset),
        .start     (ds_start),
        .hready    (hready),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .ds_active (ds_active)
    );

    // A non-zero sel_dp implies the default slave is idle, so the two never overlap
    always_comb begin
        hrdata = '0;
        hresp  = ds_hresp;
        hready = ds_hready;
        if (!ds_active) begin
            for (int unsigned i = 0; i < slv_c; i++) begin
                if (sel_dp_q[i]) begin
                    hrdata = hrdata_s[i];
                    hresp  = hresp_s[i];
                    hready = hreadyout_s[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed table-driven bench for ahb_resp_mux plus hand-written reset sequences.
module tb_ahb_resp_mux;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001,
                            D2 = 32'hDEAD_BEEF, D3 = 32'h4444_0003;

    logic             hclk = 1'b0;
    logic             hreset;
    logic [3:0]       hsel;
    logic [1:0]       htrans;
    logic [3:0][31:0] hrdata_s;
    logic [3:0]       hresp_s;
    logic [3:0]       hreadyout_s;
    logic [31:0]      hrdata;
    logic             hresp;
    logic             hready;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [1:0]  trans;
        logic [3:0]  ro;
        logic [3:0]  rs;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[21];

    ahb_resp_mux #(.slv_c(4)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .htrans      (htrans),
        .hrdata_s    (hrdata_s),
        .hresp_s     (hresp_s),
        .hreadyout_s (hreadyout_s),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .hready      (hready)
    );

    always #5 hclk = ~hclk;

    function automatic vec_t mk(logic [3:0] sel, logic [1:0] trans, logic [3:0] ro,
                                logic [3:0] rs, logic rdy, logic rsp, logic [31:0] data);
        vec_t v;
        v.sel = sel; v.trans = trans; v.ro = ro; v.rs = rs;
        v.rdy = rdy; v.rsp = rsp; v.data = data;
        return v;
    endfunction

    task automatic check3(input string name, input logic rdy, input logic rsp,
                          input logic [31:0] data);
        tests++;
        if (hready !== rdy || hresp !== rsp || hrdata !== data) begin
            failed++;
            $display("FAIL %s: got hready=%b hresp=%b hrdata=%h, want hready=%b hresp=%b hrdata=%h",
                     name, hready, hresp, hrdata, rdy, rsp, data);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [1:0] trans,
                         input logic [3:0] ro, input logic [3:0] rs);
        hsel = sel; htrans = trans; hreadyout_s = ro; hresp_s = rs;
    endtask

    initial begin
        hrdata_s[0] = D0; hrdata_s[1] = D1; hrdata_s[2] = D2; hrdata_s[3] = D3;
        drive(4'b0000, T_IDLE, 4'b1111, 4'b0000);
        hreset = 1'b1;

        // Each row: inputs for this cycle, expected outputs before the next rising edge
        vecs[0]  = mk(4'b0100, T_NSEQ, 4'b1111, 4'b0000, 1, 0, 32'h0);
        vecs[1]  = mk(4'b0000, T_IDLE, 4'b1011, 4'b0000, 0, 0, D2);
        vecs[2]  = mk(4'b0000, T_IDLE, 4'b1011, 4'b0000, 0, 0, D2);
        vecs[3]  = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1, 0, D2);
        vecs[4]  = mk(4'b0000, T_NSEQ, 4'b1111, 4'b0000, 1, 0, 32'h0);
        vecs[5]  = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 0, 1, 32'h0);
        vecs[6]  = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1, 1, 32'h0);
        vecs[7]  = mk(4'b0000, T_BUSY, 4'b1111, 4'b0000, 1, 0, 32'h0);
        vecs[8]  = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1, 0, 32'h0);
        vecs[9]  = mk(4'b1010, T_NSEQ, 4'b1111, 4'b0000, 1, 0, 32'h0);
        vecs[10] = mk(4'b0001, T_NSEQ, 4'b1111, 4'b0000, 1, 0, D1);
        vecs[11] = mk(4'b1000, T_BUSY, 4'b1111, 4'b0001, 1, 1, D0);
        vecs[12] = mk(4'b0000, T_SEQ,  4'b0111, 4'b0000, 0, 0, D3);
        vecs[13] = mk(4'b0000, T_SEQ,  4'b1111, 4'b0000, 1, 0, D3);
        vecs[14] = mk(4'b0000, T_SEQ,  4'b1111, 4'b0000, 0, 1, 32'h0);
        vecs[15] = mk(4'b0000, T_NSEQ, 4'b1111, 4'b0000, 1, 1, 32'h0);
        vecs[16] = mk(4'b0010, T_NSEQ, 4'b1111, 4'b0000, 0, 1, 32'h0);
        vecs[17] = mk(4'b0010, T_NSEQ, 4'b1111, 4'b0000, 1, 1, 32'h0);
        vecs[18] = mk(4'b0000, T_IDLE, 4'b1101, 4'b0010, 0, 1, D1);
        vecs[19] = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1, 0, D1);
        vecs[20] = mk(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1, 0, 32'h0);

        repeat (2) @(negedge hclk);
        #1 check3("reset_hold", 1, 0, 32'h0);
        @(negedge hclk);
        hreset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].sel, vecs[i].trans, vecs[i].ro, vecs[i].rs);
            #1 check3($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].rsp, vecs[i].data);
            @(negedge hclk);
        end

        // Asynchronous reset with slave 2 selected, no clock edge involved
        drive(4'b0100, T_NSEQ, 4'b1111, 4'b0000);
        @(negedge hclk);
        drive(4'b0000, T_IDLE, 4'b1111, 4'b0000);
        #1 check3("pre_async_rst", 1, 0, D2);
        #1 hreset = 1'b1;
        #1 check3("async_rst", 1, 0, 32'h0);
        @(negedge hclk);
        hreset = 1'b0;

        // Reset lands in DS_ERR1; no ERROR cycle may survive it
        drive(4'b0000, T_NSEQ, 4'b1111, 4'b0000);
        @(negedge hclk);
        drive(4'b0000, T_IDLE, 4'b1111, 4'b0000);
        #1 check3("err1_before_rst", 0, 1, 32'h0);
        #1 hreset = 1'b1;
        #1 check3("rst_in_err1", 1, 0, 32'h0);
        #1 hreset = 1'b0;
        #1 check3("after_rst_release", 1, 0, 32'h0);
        @(negedge hclk);
        drive(4'b1000, T_NSEQ, 4'b1111, 4'b0000);
        #1 check3("no_residual_err", 1, 0, 32'h0);
        @(negedge hclk);
        drive(4'b0000, T_IDLE, 4'b1111, 4'b0000);
        #1 check3("slave3_after_rst", 1, 0, D3);
        @(negedge hclk);
        #1 check3("final_idle", 1, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter slv_c, default 4, giving the number of slaves (address-decoder width).
REQ-002 SHALL have port hclk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port hreset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port hsel, input, [slv_c-1:0], address-phase select vector from the address decoder.
REQ-005 SHALL have port htrans, input, [1:0], master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-006 SHALL have port hrdata_s, input, [slv_c-1:0][31:0], per-slave read data.
REQ-007 SHALL have port hresp_s, input, [slv_c-1:0], per-slave response (0 OKAY, 1 ERROR).
REQ-008 SHALL have port hreadyout_s, input, [slv_c-1:0], per-slave ready-out.
REQ-009 SHALL have port hrdata, output, [31:0], read data to the master.
REQ-010 SHALL have port hresp, output, 1, response to the master.
REQ-011 SHALL have port hready, output, 1, global ready, also fed back to all slaves as hready.

Function
REQ-012 SHALL capture the address-phase select into a data-phase register sel_dp only on rising hclk edges where hready=1; sel_dp SHALL hold its value while hready=0.
REQ-013 When capturing with multiple hsel bits set, SHALL keep only the lowest-index set bit (priority encode) in sel_dp.
REQ-014 When capturing with hsel=0 and htrans NONSEQ or SEQ, SHALL start the default slave; sel_dp SHALL become all-zero.
REQ-015 When capturing with hsel=0 and htrans IDLE or BUSY, SHALL set sel_dp to all-zero with the default slave idle.
REQ-016 When sel_dp has bit i set, hrdata/hresp/hready SHALL equal hrdata_s[i]/hresp_s[i]/hreadyout_s[i] combinationally (zero added latency).
REQ-017 When sel_dp is zero and the default slave is idle, SHALL drive hready=1, hresp=0, hrdata=0.
REQ-018 The default-slave FSM SHALL have states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-019 DS_IDLE SHALL go to DS_ERR1 on the condition in REQ-014.
REQ-020 DS_ERR1 SHALL always go to DS_ERR2.
REQ-021 DS_ERR2 SHALL go to DS_ERR1 if REQ-014 holds again that cycle, else to DS_IDLE.
REQ-022 In DS_ERR1, SHALL drive hready=0, hresp=1, hrdata=0.
REQ-023 In DS_ERR2, SHALL drive hready=1, hresp=1, hrdata=0 (the two-cycle AHB ERROR response).
REQ-024 Selection SHALL be based on htrans/hsel of the address phase only; htrans BUSY/IDLE arriving to a selected slave SHALL still register that slave's select.
REQ-025 Back-to-back transfers to different slaves SHALL switch the mux on the first cycle of the new data phase with no bubble.

Reset
REQ-026 While hreset=1, SHALL clear sel_dp to zero and hold the FSM in DS_IDLE, independent of hclk.
REQ-027 During reset, outputs SHALL be hready=1, hresp=0, hrdata=0.
REQ-028 Reset asserted mid-transfer (including DS_ERR1) SHALL abort immediately to the reset values with no residual ERROR cycle.

Structure
REQ-029 Shared package ahb_pkg SHALL hold the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), the HRESP codes (OKAY/ERROR) and the enum type for the default-slave states.
REQ-030 The default-slave FSM SHALL be a sub-module ahb_def_slv (inputs start and hready; outputs ds_hready, ds_hresp, ds_active), instantiated once.
REQ-031 The priority encoder and mux SHALL be plain combinational logic with no further sub-modules.

Verification
REQ-032 Reset: assert hreset mid-cycle with no clock -> immediately hready=1, hresp=0, hrdata=0.
REQ-033 Basic read: slv_c=4, hsel=4'b0100, htrans=NONSEQ, hready=1, then hrdata_s[2]=32'hDEADBEEF and hreadyout_s[2]=0 for 2 cycles then 1 -> hready low 2 cycles, then hrdata=32'hDEADBEEF, hresp=0.
REQ-034 Unmapped: hsel=0, htrans=NONSEQ -> next cycle hready=0, hresp=1; following cycle hready=1, hresp=1; then idle OKAY.
REQ-035 Idle unmapped: hsel=0, htrans=IDLE -> hready stays 1 and hresp stays 0 throughout.
REQ-036 Multi-select and back-to-back: hsel=4'b1010 then hsel=4'b0001 on consecutive NONSEQ cycles -> data phases route slave 1 then slave 0 with no bubble.
REQ-037 Reset during DS_ERR1 -> hready=1, hresp=0 immediately; first NONSEQ after release to slave 3 routes normally.
